// File: rtl/imem_uart_loader.sv
// Boot loader: receives a length-prefixed program image over an 8N1 UART
// link, packs little-endian bytes into instruction words, writes them to
// instruction memory from address 0 upward, then releases the core from reset.
module imem_uart_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ROM_INS      = 32,
    parameter int unsigned ROM_ADD      = 10
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               RX,
    output logic               IMEM_WE,
    output logic [ROM_ADD-1:0] IMEM_ADDR,
    output logic [ROM_INS-1:0] IMEM_DATA,
    output logic               CORE_RSTn,
    output logic               LOADING,
    output logic               DONE,
    output logic               ERROR
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]     Depth    = 32'd1 << ROM_ADD;

    typedef enum logic [1:0] {URxIdle, URxStart, URxData, URxStop} urx_state_e;
    typedef enum logic [2:0] {LdLen0, LdLen1, LdWord, LdWrite, LdDone, LdErr} ld_state_e;

    // RX synchroniser
    logic rx_meta_q, rx_sync_q;

    // UART receiver
    urx_state_e      urx_state_q, urx_state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            start_ok;

    // Loader
    ld_state_e          ld_state_q, ld_state_d;
    logic [15:0]        len_q, len_d;
    logic [ROM_ADD:0]   word_cnt_q, word_cnt_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [ROM_INS-1:0] word_q, word_d;
    logic               we_q, we_d;
    logic [ROM_ADD-1:0] addr_q, addr_d;
    logic [ROM_INS-1:0] data_q, data_d;
    logic               core_rstn_q, core_rstn_d;
    logic               loading_q, loading_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [ROM_INS-1:0] word_tmp;
    logic [15:0]        len_full;
    logic [ROM_ADD:0]   word_cnt_inc;

    // UART receiver next state: start-bit qualify at half bit, then full-bit sampling
    always_comb begin
        urx_state_d  = urx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        start_ok     = 1'b0;
        unique case (urx_state_q)
            URxIdle: begin
                if (!rx_sync_q) begin
                    urx_state_d = URxStart;
                    clk_cnt_d   = '0;
                end
            end
            URxStart: begin
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d = '0;
                    if (rx_sync_q) begin
                        // Glitch, not a start bit
                        urx_state_d = URxIdle;
                    end else begin
                        urx_state_d = URxData;
                        bit_cnt_d   = '0;
                        start_ok    = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            URxData: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        urx_state_d = URxStop;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            URxStop: begin
                if (clk_cnt_q == BitLast) begin
                    clk_cnt_d    = '0;
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                    urx_state_d  = URxIdle;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: urx_state_d = URxIdle;
        endcase
    end

    // Loader next state: length header, word assembly, write strobes, terminal states
    always_comb begin
        ld_state_d = ld_state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        word_tmp                       = word_q;
        word_tmp[8*byte_idx_q +: 8]    = shift_q;
        len_full                       = {shift_q, len_q[7:0]};
        word_cnt_inc                   = word_cnt_q + 1'b1;

        if (frame_err_q && (ld_state_q != LdDone) && (ld_state_q != LdErr)) begin
            ld_state_d = LdErr;
        end else begin
            unique case (ld_state_q)
                LdLen0: begin
                    if (byte_valid_q) begin
                        len_d      = {8'h00, shift_q};
                        ld_state_d = LdLen1;
                    end
                end
                LdLen1: begin
                    if (byte_valid_q) begin
                        len_d = len_full;
                        if (len_full == 16'd0) begin
                            ld_state_d = LdDone;
                        end else if (32'(len_full) > Depth) begin
                            ld_state_d = LdErr;
                        end else begin
                            ld_state_d = LdWord;
                            word_cnt_d = '0;
                            byte_idx_d = '0;
                        end
                    end
                end
                LdWord: begin
                    if (byte_valid_q) begin
                        word_d     = word_tmp;
                        byte_idx_d = byte_idx_q + 1'b1;
                        if (byte_idx_q == 2'd3) begin
                            // Output registers load only here so they hold between strobes
                            ld_state_d = LdWrite;
                            we_d       = 1'b1;
                            addr_d     = word_cnt_q[ROM_ADD-1:0];
                            data_d     = word_tmp;
                        end
                    end
                end
                LdWrite: begin
                    word_cnt_d = word_cnt_inc;
                    if (32'(word_cnt_inc) == 32'(len_q)) begin
                        ld_state_d = LdDone;
                    end else begin
                        ld_state_d = LdWord;
                    end
                end
                LdDone:  ld_state_d = LdDone;
                LdErr:   ld_state_d = LdErr;
                default: ld_state_d = LdErr;
            endcase
        end

        // Status outputs are registered from the next state
        core_rstn_d = (ld_state_d == LdDone);
        done_d      = (ld_state_d == LdDone);
        error_d     = (ld_state_d == LdErr);
        if (ld_state_d == LdLen0) begin
            loading_d = loading_q | start_ok;
        end else begin
            loading_d = (ld_state_d == LdLen1) || (ld_state_d == LdWord) ||
                        (ld_state_d == LdWrite);
        end
    end

    // All state, async active-low reset
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            urx_state_q  <= URxIdle;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ld_state_q   <= LdLen0;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            core_rstn_q  <= 1'b0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rx_meta_q    <= RX;
            rx_sync_q    <= rx_meta_q;
            urx_state_q  <= urx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            ld_state_q   <= ld_state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            core_rstn_q  <= core_rstn_d;
            loading_q    <= loading_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign IMEM_WE   = we_q;
    assign IMEM_ADDR = addr_q;
    assign IMEM_DATA = data_q;
    assign CORE_RSTn = core_rstn_q;
    assign LOADING   = loading_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: byte streams go through a UART driver, a
// stream-level model predicts the writes and final status, and a monitor
// pops the predicted writes as the memory strobe fires.
module tb_imem_uart_loader;

    localparam int unsigned Cpb   = 4;
    localparam int unsigned AddW  = 4;
    localparam int          Depth = 16;

    typedef struct packed {
        logic [AddW-1:0] addr;
        logic [31:0]     data;
        logic            last;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rx = 1'b1;
    logic            we;
    logic [AddW-1:0] addr;
    logic [31:0]     data;
    logic            core_rstn, loading, done, error;

    wr_t             exp_q[$];
    logic [7:0]      stim_q[$];
    int              fe_idx = -1;
    int              chk_cnt = 0;
    int              pass_cnt = 0;
    logic [AddW-1:0] last_addr = '0;
    logic [31:0]     last_data = '0;
    bit              pending_done = 1'b0;
    bit              mon_en = 1'b0;

    always #5 clk = ~clk;

    imem_uart_loader #(
        .CLKS_PER_BIT(Cpb),
        .ROM_INS     (32),
        .ROM_ADD     (AddW)
    ) dut (
        .CLK      (clk),
        .RSTa     (rst_n),
        .RX       (rx),
        .IMEM_WE  (we),
        .IMEM_ADDR(addr),
        .IMEM_DATA(data),
        .CORE_RSTn(core_rstn),
        .LOADING  (loading),
        .DONE     (done),
        .ERROR    (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stream-level reference: length header, little-endian words, sticky end states.
    // status: 0 idle, 1 loading, 2 done, 3 error
    task automatic model_run(output int status);
        int          n;
        int          k;
        logic [31:0] w;
        wr_t         e;
        status = 0;
        n = 0;
        w = '0;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (status >= 2) break;
            if (i == fe_idx) begin
                status = 3;
                break;
            end
            status = 1;
            if (i == 0) begin
                n = int'(stim_q[i]);
            end else if (i == 1) begin
                n = n + 256 * int'(stim_q[i]);
                if (n == 0) status = 2;
                else if (n > Depth) status = 3;
            end else begin
                k = i - 2;
                w[8*(k%4) +: 8] = stim_q[i];
                if (k % 4 == 3) begin
                    e.addr = AddW'(k / 4);
                    e.data = w;
                    e.last = (k / 4 + 1 == n);
                    exp_q.push_back(e);
                    if (k / 4 + 1 == n) status = 2;
                end
            end
        end
    endtask

    task automatic apply_reset;
        tick;
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        mon_en = 1'b1;
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_core_rstn", 32'(core_rstn), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        exp_q.delete();
        pending_done = 1'b0;
        last_addr = '0;
        last_data = '0;
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (2) tick;
    endtask

    task automatic uart_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (Cpb) tick;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Cpb) tick;
        end
        rx = stop;
        repeat (Cpb) tick;
        rx = 1'b1;
    endtask

    task automatic run_stream(input int gap_max);
        for (int i = 0; i < stim_q.size(); i++) begin
            uart_byte(stim_q[i], (i != fe_idx));
            repeat ($urandom_range(0, gap_max)) tick;
        end
        rx = 1'b1;
        repeat (2 * Cpb + 8) tick;
    endtask

    task automatic check_final(input int st);
        check("final_done", 32'(done), 32'(st == 2));
        check("final_core_rstn", 32'(core_rstn), 32'(st == 2));
        check("final_error", 32'(error), 32'(st == 3));
        check("final_loading", 32'(loading), 32'(st == 1));
        check("missing_writes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_scenario(input int gap_max, input bit glitch, input bit do_reset);
        int st;
        if (do_reset) apply_reset;
        model_run(st);
        if (glitch) begin
            rx = 1'b0;
            tick;
            rx = 1'b1;
            repeat (6) tick;
        end
        run_stream(gap_max);
        check_final(st);
    endtask

    // Monitor: pops predicted writes on each strobe, checks hold and DONE timing
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (pending_done) begin
                    check("done_after_last_we", 32'(done), 32'd1);
                    check("core_rstn_after_last_we", 32'(core_rstn), 32'd1);
                    pending_done = 1'b0;
                end
                if (we) begin
                    if (exp_q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                                 addr, data);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(addr), 32'(e.addr));
                        check("wr_data", data, e.data);
                        check("done_during_we", 32'(done), 32'd0);
                        last_addr = e.addr;
                        last_data = e.data;
                        pending_done = e.last;
                    end
                end else begin
                    check("hold_addr", 32'(addr), 32'(last_addr));
                    check("hold_data", data, last_data);
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        // Two-word image
        stim_q = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        fe_idx = -1;
        run_scenario(2, 1'b0, 1'b1);
        // Empty image, trailing traffic ignored
        stim_q = {8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_scenario(1, 1'b0, 1'b1);
        // Oversize (17 > 16), trailing traffic ignored
        stim_q = {8'h11, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        run_scenario(1, 1'b0, 1'b1);
        // Framing error on the first payload byte
        stim_q = {8'h01, 8'h00, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44};
        fe_idx = 2;
        run_scenario(1, 1'b0, 1'b1);
        fe_idx = -1;
        // False start glitch before a valid one-word image
        stim_q = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_scenario(0, 1'b1, 1'b1);
        // Reset mid-load: left in progress, then the next reset aborts it
        stim_q = {8'h02, 8'h00, 8'h11, 8'h22};
        run_scenario(0, 1'b0, 1'b1);
        stim_q = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_scenario(0, 1'b0, 1'b1);
        // Random images; the first fills the whole memory
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? Depth : int'($urandom_range(1, Depth));
            stim_q = {8'(n), 8'(n >> 8)};
            for (int j = 0; j < 4 * n + 4; j++) stim_q.push_back(8'($urandom_range(0, 255)));
            run_scenario(3, 1'b0, 1'b1);
        end
        // Random oversize length
        n = int'($urandom_range(Depth + 1, 65535));
        stim_q = {8'(n), 8'(n >> 8)};
        for (int j = 0; j < 8; j++) stim_q.push_back(8'($urandom_range(0, 255)));
        run_scenario(2, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
Boot-time program loader upstream of the instruction ROM port. Receives a program image over a UART serial line, assembles bytes into 32-bit instruction words, and writes them sequentially into instruction memory. Holds the core in reset until the image is complete. Once loaded, it releases the core, which then fetches from address 0.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit period (50 MHz / 115200); must be >= 4.
ROM_INS, 32, instruction word width; fixed at 32.
ROM_ADD, 10, instruction memory address width; depth = 2^ROM_ADD words.

Ports:
CLK  in  1  system clock, rising edge.
RSTa  in  1  asynchronous reset, active-low.
RX  in  1  UART serial input, 8N1, LSB first, idle high, asynchronous to CLK.
IMEM_WE  out  1  one-cycle write strobe to instruction memory.
IMEM_ADDR  out  ROM_ADD  word address of the current write.
IMEM_DATA  out  ROM_INS  instruction word being written.
CORE_RSTn  out  1  active-low reset to the core; low until load completes.
LOADING  out  1  high while the image is being received.
DONE  out  1  high from load completion until the next reset.
ERROR  out  1  sticky error flag.

Behaviour:
- Reset (RSTa low, async): all outputs 0 except CORE_RSTn=0. RX synchroniser flops reset to 1. FSM=IDLE_LEN, counters=0.
- RX passes through a 2-flop synchroniser; all decoding uses the synchronised value.
- UART RX sub-FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on synchronised RX=0.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then resample. If RX=1, this is a false start: return to IDLE with no byte and no error. Otherwise go to DATA.
  - DATA: sample one bit every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, emit a byte_valid pulse for 1 cycle. If 0, raise a framing error.
- Loader FSM states: LEN0, LEN1, WORD, WRITE, DONE_S, ERR.
  - LEN0: first byte becomes N[7:0]. LEN1: second byte becomes N[15:8].
  - At the end of LEN1: if N==0, go to DONE_S. If N > 2^ROM_ADD, go to ERR. Otherwise go to WORD with word counter=0 and byte index=0.
  - WORD: bytes are little-endian. Byte index b goes to IMEM_DATA[8b+7:8b]. After the 4th byte, go to WRITE.
  - WRITE: IMEM_WE=1 for exactly 1 cycle, with IMEM_ADDR = word counter and IMEM_DATA = the assembled word. The word counter then increments. If counter+1 == N, go to DONE_S, else back to WORD.
  - DONE_S: DONE=1 and CORE_RSTn=1, held until RSTa. Further RX traffic is ignored.
  - ERR: ERROR=1 and CORE_RSTn=0, held until RSTa. Further RX is ignored.
  - A framing error in any state other than DONE_S/ERR goes to ERR.
- Output timing:
  - LOADING=1 in LEN0 after the first start bit is detected, and in LEN1, WORD and WRITE. It is 0 otherwise.
  - IMEM_WE occurs 1 cycle after the 4th byte_valid of a word.
  - DONE and CORE_RSTn rise on the cycle after the last IMEM_WE.
- Write addresses are 0..N-1 with no wrap. N == 2^ROM_ADD is legal and the last address is all-ones. The counter is ROM_ADD+1 bits wide so the comparison does not overflow.
- IMEM_ADDR and IMEM_DATA keep their last values when IMEM_WE=0.
- Reset mid-load: everything is aborted and CORE_RSTn=0. The next frame is treated as LEN0. Memory contents are not cleared.

Test Plan:
(All scenarios use CLKS_PER_BIT=4 and ROM_ADD=4.)
- Load 2 words: send bytes 02 00 13 00 00 00 93 00 10 00. Expect IMEM_WE twice: addr 0 data 0x00000013, then addr 1 data 0x00100093. DONE=1 and CORE_RSTn=1 one cycle after the second strobe. ERROR=0.
- Empty image: send 00 00. Expect no IMEM_WE, DONE=1, CORE_RSTn=1.
- Oversize: send 11 00 (N=17 > 16). Expect ERROR=1, CORE_RSTn=0, no IMEM_WE. Subsequent bytes have no effect.
- Framing error: send 01 00, then a byte whose stop bit is 0. Expect ERROR=1, no IMEM_WE, CORE_RSTn=0.
- False start: drive a 1-cycle low glitch on RX (post-synchroniser), then a valid 01 00 AA BB CC DD. Expect a single write at addr 0 with data 0xDDCCBBAA, then DONE=1.
- Reset mid-load: send 02 00 plus 2 bytes, pulse RSTa low. Expect all outputs at reset values immediately. Then send 01 00 EF BE AD DE: expect a write at addr 0 with data 0xDEADBEEF and DONE=1.
